// File: rtl/cu_multi_cycle_if.sv
// cu_multi_cycle_if
//   Memory handshake between the multi-cycle control unit and the unified
//   instruction/data memory port.
//   mem_req   : access request, held until mem_ready (CU -> memory)
//   mem_write : the request is a write (CU -> memory)
//   mem_ready : write accepted / read data returned this cycle (memory -> CU)
//   Modports: master = control unit, slave = memory side.
interface cu_multi_cycle_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_req, output mem_write, input mem_ready);
  modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/cu_multi_cycle.sv
// cu_multi_cycle
//   Moore control unit for the multi-cycle RV32I-subset core (lw, sw, R-type,
//   I-type ALU, beq, jal). Sequences the shared ALU and the unified memory
//   port over 3-5 states per instruction and stalls on the memory handshake.
//   Ports:
//     clk, rst            clock (rising edge), synchronous active-high reset
//     opcode/funct3/funct7_5  instruction fields from the IR
//     zero                ALU zero flag
//     mem (master)        mem_req / mem_write / mem_ready handshake
//     adr_src, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
//     imm_src, result_src, alu_ctrl   datapath controls
//     state_o             current state encoding (debug)
//     mem_timeout         sticky flag, set when a stall reaches MEM_TIMEOUT
//     illegal_instr       only with CU_MC_ILLEGAL_TRAP_EN: high in TRAP
//   Parameter MEM_TIMEOUT: stall-cycle limit, 0 disables the check.
//   Macro CU_MC_ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOPs.
//
//   state  | code | meaning
//   FETCH  | 0    | read instruction at PC, PC <= PC + 4 on mem_ready
//   DECODE | 1    | ALUOut <= OldPC + Imm (branch/jump target)
//   MEMADR | 2    | ALUOut <= RD1 + Imm (load/store address)
//   MEMRD  | 3    | load read at ALUOut
//   MEMWB  | 4    | write read data to rd
//   MEMWR  | 5    | store write at ALUOut
//   EXECR  | 6    | R-type ALU op
//   EXECI  | 7    | I-type ALU op
//   ALUWB  | 8    | write ALUOut to rd
//   BEQ    | 9    | compare, PC <= ALUOut if equal
//   JAL    | 10   | PC <= ALUOut, ALUOut <= OldPC + 4
//   TRAP   | 11   | illegal opcode, all enables off until rst
module cu_multi_cycle #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  cu_multi_cycle_if.master      mem,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            result_src,
  output logic [2:0]            alu_ctrl,
  output logic [3:0]            state_o,
`ifdef CU_MC_ILLEGAL_TRAP_EN
  output logic                  illegal_instr,
`endif
  output logic                  mem_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXECR  = 4'd6,  EXECI = 4'd7,
    ALUWB  = 4'd8,  BEQ    = 4'd9,  JAL    = 4'd10, TRAP  = 4'd11
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_FUNC} alu_op_t;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // With the check disabled the counter simply saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_LIM =
    (MEM_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic    req_raw, write_raw, ir_raw, pc_update, branch, regw_raw;
  alu_op_t alu_op;
  logic [2:0] func_ctrl;

  // Control decode from the current state
  always_comb begin
    req_raw    = 1'b0;
    write_raw  = 1'b0;
    adr_src    = 1'b0;
    ir_raw     = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    regw_raw   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = OP_ADD;
    case (state_q)
      FETCH: begin
        req_raw = 1'b1;
        if (mem.mem_ready) begin
          ir_raw     = 1'b1;
          pc_update  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      DECODE: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      MEMADR: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      MEMRD:  begin req_raw = 1'b1; adr_src = 1'b1; end
      MEMWB:  begin result_src = 2'b01; regw_raw = 1'b1; end
      MEMWR:  begin req_raw = 1'b1; write_raw = 1'b1; adr_src = 1'b1; end
      EXECR:  begin alu_src_a = 2'b10; alu_op = OP_FUNC; end
      EXECI:  begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = OP_FUNC; end
      ALUWB:  regw_raw = 1'b1;
      BEQ:    begin alu_src_a = 2'b10; alu_op = OP_SUB; branch = 1'b1; end
      JAL:    begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
      default: ;
    endcase
  end

  // opcode[5] separates R-type (sub allowed) from I-type (addi only)
  always_comb begin
    case (funct3)
      3'b000:  func_ctrl = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
      3'b010:  func_ctrl = 3'b101;
      3'b110:  func_ctrl = 3'b011;
      3'b111:  func_ctrl = 3'b010;
      default: func_ctrl = 3'b000;
    endcase
    case (alu_op)
      OP_SUB:  alu_ctrl = 3'b001;
      OP_FUNC: alu_ctrl = func_ctrl;
      default: alu_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    case (opcode)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  // Write enables and requests are suppressed while rst is high
  assign mem.mem_req   = req_raw & ~rst;
  assign mem.mem_write = write_raw & ~rst;
  assign ir_write      = ir_raw & ~rst;
  assign pc_write      = (pc_update | (branch & zero)) & ~rst;
  assign reg_write     = regw_raw & ~rst;
  assign state_o       = state_q;
  assign mem_timeout   = timeout_q;
`ifdef CU_MC_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == TRAP);
`endif

  // Next state, stall counter and timeout flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      FETCH:  if (mem.mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BEQ;
          7'b1101111:             state_d = JAL;
`ifdef CU_MC_ILLEGAL_TRAP_EN
          default:                state_d = TRAP;
`else
          default:                state_d = FETCH;
`endif
        endcase
      end
      MEMADR: state_d = opcode[5] ? MEMWR : MEMRD;
      MEMRD:  if (mem.mem_ready) state_d = MEMWB;
      MEMWR:  if (mem.mem_ready) state_d = FETCH;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      JAL:    state_d = ALUWB;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
    if (req_raw) begin
      if (mem.mem_ready)      cnt_d = '0;
      else if (cnt_q != CNT_LIM) cnt_d = cnt_q + 1'b1;
    end
    if ((MEM_TIMEOUT != 0) && (cnt_d == CNT_LIM)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cu_multi_cycle.sv
module tb_cu_multi_cycle;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0;
  logic zero = 1'b0;
  logic adr_src, ir_write, pc_write, reg_write, mem_timeout;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
`ifdef CU_MC_ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cu_multi_cycle_if mem_if ();

  cu_multi_cycle #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem(mem_if), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .state_o(state_o),
`ifdef CU_MC_ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_if.mem_ready = 1'b1; opcode = OP_R;
    step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_FETCH) begin n_err++; $display("FAIL reset_state got %0d exp %0d", state_o, S_FETCH); end
    n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b exp 0", mem_if.mem_req); end
    n_cmp++; if (pc_write !== 1'b0 || ir_write !== 1'b0) begin n_err++; $display("FAIL reset_enables got pc=%b ir=%b exp 0", pc_write, ir_write); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
    step();
    rst = 1'b0;
  endtask

  // R-type with funct7_5 selecting add/sub; ends back in FETCH
  task automatic test_rtype(input logic f75, input logic [2:0] exp_ctrl);
    opcode = OP_R; funct3 = 3'b000; funct7_5 = f75; mem_if.mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (state_o !== S_FETCH || mem_if.mem_req !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1)
      begin n_err++; $display("FAIL r_fetch got st=%0d req=%b ir=%b pc=%b exp 0/1/1/1", state_o, mem_if.mem_req, ir_write, pc_write); end
    n_cmp++; if (result_src !== 2'b10 || alu_src_b !== 2'b10 || alu_ctrl !== 3'b000)
      begin n_err++; $display("FAIL r_fetch_alu got rs=%b b=%b ac=%b exp 10/10/000", result_src, alu_src_b, alu_ctrl); end
    step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_DECODE || alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || mem_if.mem_req !== 1'b0)
      begin n_err++; $display("FAIL r_decode got st=%0d a=%b b=%b req=%b exp 1/01/01/0", state_o, alu_src_a, alu_src_b, mem_if.mem_req); end
    step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_EXECR || alu_ctrl !== exp_ctrl || alu_src_a !== 2'b10 || alu_src_b !== 2'b00)
      begin n_err++; $display("FAIL r_exec got st=%0d ac=%b a=%b b=%b exp 6/%b/10/00", state_o, alu_ctrl, alu_src_a, alu_src_b, exp_ctrl); end
    step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_ALUWB || reg_write !== 1'b1 || result_src !== 2'b00)
      begin n_err++; $display("FAIL r_aluwb got st=%0d rw=%b rs=%b exp 8/1/00", state_o, reg_write, result_src); end
    step();
    n_cmp++; if (state_o !== S_FETCH) begin n_err++; $display("FAIL r_done got %0d exp 0", state_o); end
  endtask

  task automatic test_itype(input logic [2:0] f3, input logic f75, input logic [2:0] exp_ctrl);
    opcode = OP_I; funct3 = f3; funct7_5 = f75; mem_if.mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_EXECI || alu_ctrl !== exp_ctrl || alu_src_b !== 2'b01 || imm_src !== 2'b00)
      begin n_err++; $display("FAIL i_exec got st=%0d ac=%b b=%b imm=%b exp 7/%b/01/00", state_o, alu_ctrl, alu_src_b, imm_src, exp_ctrl); end
    step(); step();
  endtask

  task automatic test_lw_stall();
    int n;
    opcode = OP_LW; funct3 = 3'b010; funct7_5 = 1'b0; mem_if.mem_ready = 1'b1;
    n = 0;
    step(); n++;
    step(); n++;
    @(negedge clk);
    n_cmp++; if (state_o !== S_MEMADR || alu_src_a !== 2'b10 || alu_src_b !== 2'b01 || alu_ctrl !== 3'b000)
      begin n_err++; $display("FAIL lw_memadr got st=%0d a=%b b=%b ac=%b exp 2/10/01/000", state_o, alu_src_a, alu_src_b, alu_ctrl); end
    step(); n++;
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_if.mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (state_o !== S_MEMRD || mem_if.mem_req !== 1'b1 || adr_src !== 1'b1 || reg_write !== 1'b0)
        begin n_err++; $display("FAIL lw_memrd%0d got st=%0d req=%b adr=%b rw=%b exp 3/1/1/0", i, state_o, mem_if.mem_req, adr_src, reg_write); end
      step(); n++;
    end
    @(negedge clk);
    n_cmp++; if (state_o !== S_MEMWB || result_src !== 2'b01 || reg_write !== 1'b1)
      begin n_err++; $display("FAIL lw_memwb got st=%0d rs=%b rw=%b exp 4/01/1", state_o, result_src, reg_write); end
    step(); n++;
    n_cmp++; if (state_o !== S_FETCH || n !== 8) begin n_err++; $display("FAIL lw_cycles got st=%0d n=%0d exp 0/8", state_o, n); end
  endtask

  task automatic test_sw();
    opcode = OP_SW; funct3 = 3'b010; mem_if.mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (imm_src !== 2'b01) begin n_err++; $display("FAIL sw_imm got %b exp 01", imm_src); end
    step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_MEMWR || mem_if.mem_write !== 1'b1 || mem_if.mem_req !== 1'b1 || adr_src !== 1'b1)
      begin n_err++; $display("FAIL sw_memwr got st=%0d w=%b req=%b adr=%b exp 5/1/1/1", state_o, mem_if.mem_write, mem_if.mem_req, adr_src); end
    step();
  endtask

  task automatic test_beq(input logic z);
    opcode = OP_BEQ; funct3 = 3'b000; zero = z; mem_if.mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_BEQ || pc_write !== z || alu_ctrl !== 3'b001 || imm_src !== 2'b10)
      begin n_err++; $display("FAIL beq_z%b got st=%0d pc=%b ac=%b imm=%b exp 9/%b/001/10", z, state_o, pc_write, alu_ctrl, imm_src, z); end
    step();
    zero = 1'b0;
  endtask

  // Zero-wait cycle count from FETCH back to FETCH
  task automatic test_count(input logic [6:0] op, input int exp_n);
    int n;
    opcode = op; funct3 = 3'b000; mem_if.mem_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (state_o != S_FETCH && n < 20);
    n_cmp++; if (n !== exp_n) begin n_err++; $display("FAIL cycles_op%b got %0d exp %0d", op, n, exp_n); end
  endtask

  task automatic test_jal();
    opcode = OP_JAL; mem_if.mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (state_o !== S_JAL || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || imm_src !== 2'b11)
      begin n_err++; $display("FAIL jal got st=%0d pc=%b a=%b b=%b imm=%b exp 10/1/01/10/11", state_o, pc_write, alu_src_a, alu_src_b, imm_src); end
    step(); step();
  endtask

  task automatic test_mid_reset();
    opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; mem_if.mem_ready = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (state_o !== S_ALUWB || reg_write !== 1'b0)
      begin n_err++; $display("FAIL midrst_rw got st=%0d rw=%b exp 8/0", state_o, reg_write); end
    step();
    n_cmp++; if (state_o !== S_FETCH) begin n_err++; $display("FAIL midrst_state got %0d exp 0", state_o); end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_R; mem_if.mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (mem_timeout !== 1'b0 || state_o !== S_FETCH)
        begin n_err++; $display("FAIL to_early%0d got to=%b st=%0d exp 0/0", i, mem_timeout, state_o); end
    end
    step();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL to_rise got %b exp 1", mem_timeout); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (mem_timeout !== 1'b1 || state_o !== S_FETCH)
        begin n_err++; $display("FAIL to_hold%0d got to=%b st=%0d exp 1/0", i, mem_timeout, state_o); end
    end
    mem_if.mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ir_write !== 1'b1) begin n_err++; $display("FAIL to_fetch_ir got %b exp 1", ir_write); end
    step();
    n_cmp++; if (state_o !== S_DECODE || mem_timeout !== 1'b1)
      begin n_err++; $display("FAIL to_after got st=%0d to=%b exp 1/1", state_o, mem_timeout); end
    step(); step(); step();
    do_reset();
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL to_clear got %b exp 0", mem_timeout); end
  endtask

  task automatic test_illegal();
    opcode = 7'h7F; mem_if.mem_ready = 1'b1;
    step();
    n_cmp++; if (state_o !== S_DECODE) begin n_err++; $display("FAIL ill_decode got %0d exp 1", state_o); end
    step();
`ifdef CU_MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (state_o !== S_TRAP || illegal_instr !== 1'b1 || mem_if.mem_req !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0)
        begin n_err++; $display("FAIL ill_trap%0d got st=%0d ill=%b req=%b pc=%b exp 11/1/0/0", i, state_o, illegal_instr, mem_if.mem_req, pc_write); end
      step();
    end
    do_reset();
    n_cmp++; if (state_o !== S_FETCH || illegal_instr !== 1'b0)
      begin n_err++; $display("FAIL ill_reset got st=%0d ill=%b exp 0/0", state_o, illegal_instr); end
`else
    n_cmp++; if (state_o !== S_FETCH) begin n_err++; $display("FAIL ill_nop got %0d exp 0", state_o); end
`endif
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;
    test_reset();
    test_rtype(1'b0, 3'b000);
    test_rtype(1'b1, 3'b001);
    test_itype(3'b000, 1'b1, 3'b000);
    test_itype(3'b110, 1'b0, 3'b011);
    test_itype(3'b010, 1'b0, 3'b101);
    test_lw_stall();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_count(OP_LW, 5);
    test_count(OP_SW, 4);
    test_count(OP_R, 4);
    test_count(OP_I, 4);
    test_count(OP_BEQ, 3);
    test_count(OP_JAL, 4);
    test_mid_reset();
    test_timeout();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
